// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Writer side of the instruction-memory interface. Accepts an
//               image as a byte stream (valid/ready), packs every four bytes
//               into a little-endian 32-bit word and writes the words to
//               consecutive word-aligned addresses starting at BASE_ADDR.
//               The core is held in reset (o_core_hold) until the whole
//               image has been written.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   BASE_ADDR      byte address of the first word written
//   MAX_WORDS      longest accepted image, in words
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   i_start        one-cycle load request, honoured in IDLE or DONE only
//   i_len[15:0]    image length in words, sampled with i_start
//   i_byte_valid   i_byte_data carries a byte
//   i_byte_data    image byte
//   o_byte_ready   loader accepts a byte this cycle (decoded from state)
//   o_imem_w_en    instruction-memory write strobe, one cycle per word
//   o_imem_w_addr  word-aligned byte address of the write
//   o_imem_w_data  write data
//   o_core_hold    1 = keep the core in reset
//   o_done         image loaded, core released
//   o_err          sticky error, cleared by the next accepted start
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  when defined, one trailing byte equal to the
//                            XOR of all image bytes must follow the last
//                            word before the core is released.
// ============================================================================
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [15:0] i_len,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte_data,
   output logic        o_byte_ready,
   output logic        o_imem_w_en,
   output logic [31:0] o_imem_w_addr,
   output logic [31:0] o_imem_w_data,
   output logic        o_core_hold,
   output logic        o_done,
   output logic        o_err
);

   localparam int unsigned c_CNT_W = $clog2(MAX_WORDS) + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      S_CHECK = 3'd4
`endif
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_len;
   logic [c_CNT_W-1:0]   r_widx;
   logic [1:0]           r_bidx;
   logic [23:0]          r_buf;     // bytes 0..2 of the word in progress
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]           r_csum;
`endif

   logic                 w_len_ok;
   logic                 w_xfer;
   logic [c_CNT_W-1:0]   w_widx_nxt;
   logic                 w_last;
   logic [31:0]          w_addr;

   // Length check done in 32 bits so the full 16-bit input is compared.
   assign w_len_ok   = (i_len != 16'd0) && ({16'd0, i_len} <= 32'(MAX_WORDS));
   assign w_widx_nxt = r_widx + c_CNT_W'(1);
   assign w_last     = (w_widx_nxt == r_len);
   // Address arithmetic wraps naturally at 32 bits.
   assign w_addr     = BASE_ADDR + (32'(r_widx) << 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign o_byte_ready = (r_state == S_RECV) || (r_state == S_CHECK);
`else
   assign o_byte_ready = (r_state == S_RECV);
`endif

   assign w_xfer = i_byte_valid && o_byte_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_len         <= '0;
         r_widx        <= '0;
         r_bidx        <= 2'd0;
         r_buf         <= 24'd0;
         o_imem_w_en   <= 1'b0;
         o_imem_w_addr <= BASE_ADDR;
         o_imem_w_data <= 32'd0;
         o_core_hold   <= 1'b1;
         o_done        <= 1'b0;
         o_err         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum        <= 8'd0;
`endif
      end else begin
         // The strobe is only raised for the single WRITE cycle.
         o_imem_w_en <= 1'b0;

         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  // Any start (good or bad) takes the core back into reset.
                  o_done      <= 1'b0;
                  o_core_hold <= 1'b1;
                  if (w_len_ok) begin
                     r_len   <= i_len[c_CNT_W-1:0];
                     r_widx  <= '0;
                     r_bidx  <= 2'd0;
                     o_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_csum  <= 8'd0;
`endif
                     r_state <= S_RECV;
                  end else begin
                     o_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end

            S_RECV: begin
               if (w_xfer) begin
                  r_bidx <= r_bidx + 2'd1;   // wraps to 0 after the 4th byte
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ i_byte_data;
`endif
                  case (r_bidx)
                     2'd0: r_buf[7:0]   <= i_byte_data;
                     2'd1: r_buf[15:8]  <= i_byte_data;
                     2'd2: r_buf[23:16] <= i_byte_data;
                     2'd3: begin
                        // Present the write during the WRITE cycle itself.
                        o_imem_w_en   <= 1'b1;
                        o_imem_w_addr <= w_addr;
                        o_imem_w_data <= {i_byte_data, r_buf};
                        r_state       <= S_WRITE;
                     end
                  endcase
               end
            end

            S_WRITE: begin
               r_widx <= w_widx_nxt;
               if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state     <= S_CHECK;
`else
                  r_state     <= S_DONE;
                  o_done      <= 1'b1;
                  o_core_hold <= 1'b0;
`endif
               end else begin
                  r_state <= S_RECV;
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (w_xfer) begin
                  if (i_byte_data == r_csum) begin
                     r_state     <= S_DONE;
                     o_done      <= 1'b1;
                     o_core_hold <= 1'b0;
                  end else begin
                     // Written words stay in memory; the core stays held.
                     o_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
`endif

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The core's fetch path only reads instruction memory; this block fills it.
- Receives a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. Writes the words to consecutive instruction-memory addresses.
- Holds the core in reset (core_hold) until the image is fully loaded. Sits beside the instruction memory, ahead of the core's PC/fetch logic.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 256, maximum image length in words. Sizes the word counter at clog2(MAX_WORDS)+1 bits.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse that begins a load. Sampled only in IDLE or DONE.
- len  in  16  image length in words. Sampled with start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  incoming image byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_w_en  out  1  instruction-memory write strobe, one cycle per word.
- imem_w_addr  out  32  byte address of the write, always word-aligned.
- imem_w_data  out  32  write data.
- core_hold  out  1  1 = keep the core in reset.
- done  out  1  image loaded; core released.
- err  out  1  sticky error flag. Cleared by the next accepted start.

Behaviour:
- Reset: one clock only; reset is synchronous and active-low. While rst==0 at a rising edge, the block enters IDLE and sets:
  - byte_ready=0, imem_w_en=0, imem_w_addr=BASE_ADDR, imem_w_data=0
  - core_hold=1, done=0, err=0
  - word index=0, byte index=0
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - core_hold=1, byte_ready=0.
  - start with 1<=len<=MAX_WORDS: latch len, clear err and indices, go to RECV.
  - start with len==0 or len>MAX_WORDS: set err=1 and stay in IDLE.
- RECV:
  - byte_ready=1.
  - A byte transfers when byte_valid && byte_ready. It goes into lane [8*b+7:8*b] of the word buffer, where b = byte index (0..3); the first byte is the LSB.
  - On the 4th transfer, go to WRITE.
  - byte_valid low inserts stall cycles with no state change.
- WRITE (exactly 1 cycle):
  - byte_ready=0, imem_w_en=1.
  - imem_w_addr = BASE_ADDR + 4*word_index, computed mod 2^32.
  - imem_w_data = assembled word.
  - Next cycle: increment word_index. If word_index+1 == len, go to DONE; otherwise return to RECV with byte index 0.
- DONE:
  - core_hold=0, done=1, byte_ready=0.
  - start is handled as in IDLE. A valid start goes to RECV with core_hold=1 and done=0 in the next cycle. An invalid start sets err and goes to IDLE.
- start in RECV or WRITE is ignored.
- Byte-to-write latency: the word is written on the cycle after its 4th byte is accepted.
- rst asserted mid-load: return to IDLE. Partial words are discarded and never written; core_hold=1.
- Outputs are registered except byte_ready, which decodes from state.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last WRITE, the FSM enters CHECK instead of DONE.
  - CHECK asserts byte_ready=1 and accepts one extra byte.
  - That byte must equal the XOR of all 4*len image bytes, accumulated at acceptance.
  - Match: go to DONE.
  - Mismatch: set err=1, go to IDLE, core_hold stays 1. Words already written are not rolled back.
- When undefined: no CHECK state, no accumulator; the last WRITE goes directly to DONE.

Test Plan:
- Reset, then idle 5 cycles: core_hold=1, done=0, byte_ready=0, imem_w_en=0, err=0.
- start, len=2, bytes 13 00 00 00 93 00 10 00 with no stalls:
  - write 1: addr 0x0, data 0x00000013.
  - write 2: addr 0x4, data 0x00100093.
  - Each write is one cycle after its 4th byte. done=1 and core_hold=0 one cycle after the second write.
- len=1 with byte_valid toggling every other cycle, bytes AA BB CC DD: single write of 0xDDCCBBAA. No byte is lost or duplicated during stalls.
- start with len=0, then len=MAX_WORDS+1: err=1, state stays IDLE, no writes. A following valid start clears err.
- rst low after 6 bytes of a len=2 load: exactly one write (word 0) has occurred. The partial word is never written; core_hold=1.
- With IMEM_LOADER_CHECKSUM_EN, len=1, bytes 01 02 04 08:
  - checksum byte 0x0F: done=1.
  - checksum byte 0x0E: err=1, core_hold=1, state IDLE.
